// File: rtl/urna_vote_fsm_param.sv
// Ballot-entry FSM and saturating tally engine for the voting machine.
// Collects keypad digits, classifies them against candidate codes and commits on confirm.
module urna_vote_fsm_param #(
  parameter int unsigned NUM_CAND    = 2,
  parameter int unsigned CODE_DIGITS = 2,
  parameter int unsigned TALLY_W     = 8,
  parameter logic [NUM_CAND*CODE_DIGITS*4-1:0] CAND_CODES = 16'h2213
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [3:0]                         digit,
  input  logic                               digit_valid,
  input  logic                               confirm,
  input  logic                               cancel,
  input  logic                               blank,
  input  logic                               finish,
  input  logic [$clog2(NUM_CAND+2)-1:0]      rd_sel,
  output logic [CODE_DIGITS*4-1:0]           disp_digits,
  output logic [$clog2(NUM_CAND+2)-1:0]      match_idx,
  output logic [1:0]                         vote_status,
  output logic [2:0]                         state,
  output logic [TALLY_W-1:0]                 rd_data,
  output logic [TALLY_W-1:0]                 total,
  output logic                               locked
);

  localparam int unsigned SEL_W = $clog2(NUM_CAND + 2);
  localparam int unsigned CNT_W = $clog2(CODE_DIGITS + 1);
  localparam int unsigned DW    = CODE_DIGITS * 4;
  localparam int unsigned NT    = NUM_CAND + 2;

  localparam logic [SEL_W-1:0] NULL_IDX  = SEL_W'(NUM_CAND);
  localparam logic [SEL_W-1:0] BLANK_IDX = SEL_W'(NUM_CAND + 1);
  localparam logic [DW-1:0]    NO_DIGITS = {CODE_DIGITS{4'hD}};
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CODE_DIGITS - 1);

  typedef enum logic [2:0] {
    S_ENTRY  = 3'd0,
    S_REVIEW = 3'd1,
    S_COMMIT = 3'd2,
    S_LOCKED = 3'd3
  } state_e;

  state_e             state_q, state_d;
  logic [DW-1:0]      digits_q, digits_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   match_idx_q, match_idx_d;
  logic [1:0]         vote_status_q, vote_status_d;
  logic [TALLY_W-1:0] rd_data_q, rd_data_d;
  logic [TALLY_W-1:0] total_q, total_d;
  logic               locked_q, locked_d;
  logic [TALLY_W-1:0] tally_q [NT];
  logic [TALLY_W-1:0] tally_d [NT];
  logic               clear_entry;

  // Lowest-index candidate whose code equals the entry; non-decimal nibbles never match.
  function automatic logic [SEL_W-1:0] classify(input logic [DW-1:0] entry);
    logic [SEL_W-1:0] idx;
    logic             decimal;
    decimal = 1'b1;
    for (int k = 0; k < int'(CODE_DIGITS); k++) begin
      if (entry[k*4 +: 4] > 4'd9) decimal = 1'b0;
    end
    idx = NULL_IDX;
    for (int i = int'(NUM_CAND) - 1; i >= 0; i--) begin
      if (decimal && (entry == CAND_CODES[i*DW +: DW])) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= S_ENTRY;
    else          state_q <= state_d;
  end

  // Next-state logic; finish outranks every other strobe in every state.
  always_comb begin
    state_d = state_q;
    if (finish) begin
      state_d = S_LOCKED;
    end else begin
      case (state_q)
        S_ENTRY: begin
          if (cancel || confirm) begin
            state_d = S_ENTRY;
          end else if (blank) begin
            if (cnt_q == '0) state_d = S_REVIEW;
          end else if (digit_valid && (cnt_q == LAST_CNT)) begin
            state_d = S_REVIEW;
          end
        end
        S_REVIEW: begin
          if (cancel)       state_d = S_ENTRY;
          else if (confirm) state_d = S_COMMIT;
        end
        S_COMMIT: state_d = S_ENTRY;
        S_LOCKED: state_d = S_LOCKED;
        default:  state_d = S_ENTRY;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    digits_d      = digits_q;
    cnt_d         = cnt_q;
    match_idx_d   = match_idx_q;
    vote_status_d = vote_status_q;
    total_d       = total_q;
    tally_d       = tally_q;
    clear_entry   = 1'b0;
    rd_data_d     = '0;
    locked_d      = (state_d == S_LOCKED);

    case (state_q)
      S_ENTRY: begin
        if (finish || cancel) begin
          clear_entry = 1'b1;
        end else if (confirm) begin
          clear_entry = 1'b0;
        end else if (blank) begin
          if (cnt_q == '0) match_idx_d = BLANK_IDX;
        end else if (digit_valid) begin
          for (int i = 0; i < int'(CODE_DIGITS); i++) begin
            if (cnt_q == CNT_W'(i)) digits_d[(int'(CODE_DIGITS) - 1 - i)*4 +: 4] = digit;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == '0) vote_status_d = 2'b00;
          if (cnt_q == LAST_CNT) match_idx_d = classify(digits_d);
        end
      end
      S_REVIEW: begin
        if (finish || cancel) clear_entry = 1'b1;
      end
      S_COMMIT: begin
        // Completes even when finish arrives in the same cycle.
        for (int i = 0; i < int'(NT); i++) begin
          if ((match_idx_q == SEL_W'(i)) && (tally_q[i] != '1)) begin
            tally_d[i] = tally_q[i] + TALLY_W'(1);
          end
        end
        if (total_q != '1) total_d = total_q + TALLY_W'(1);
        if (match_idx_q < NULL_IDX)       vote_status_d = 2'b01;
        else if (match_idx_q == NULL_IDX) vote_status_d = 2'b10;
        else                              vote_status_d = 2'b11;
        clear_entry = 1'b1;
      end
      S_LOCKED: clear_entry = 1'b0;
      default:  clear_entry = 1'b1;
    endcase

    if (clear_entry) begin
      digits_d = NO_DIGITS;
      cnt_d    = '0;
    end

    for (int i = 0; i < int'(NT); i++) begin
      if (rd_sel == SEL_W'(i)) rd_data_d = tally_q[i];
    end
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      digits_q      <= NO_DIGITS;
      cnt_q         <= '0;
      match_idx_q   <= '0;
      vote_status_q <= 2'b00;
      rd_data_q     <= '0;
      total_q       <= '0;
      locked_q      <= 1'b0;
      for (int i = 0; i < int'(NT); i++) tally_q[i] <= '0;
    end else begin
      digits_q      <= digits_d;
      cnt_q         <= cnt_d;
      match_idx_q   <= match_idx_d;
      vote_status_q <= vote_status_d;
      rd_data_q     <= rd_data_d;
      total_q       <= total_d;
      locked_q      <= locked_d;
      for (int i = 0; i < int'(NT); i++) tally_q[i] <= tally_d[i];
    end
  end

  assign disp_digits = digits_q;
  assign match_idx   = match_idx_q;
  assign vote_status = vote_status_q;
  assign state       = state_q;
  assign rd_data     = rd_data_q;
  assign total       = total_q;
  assign locked      = locked_q;

endmodule
